// File: rtl/vga_capture_8_pkg.sv
// Shared constants, capture FSM encoding and RGB332 packing for vga_capture_8.
package vga_capture_8_pkg;

    localparam int unsigned TILE_SHIFT = 4;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned COORD_W    = 11;
    localparam int unsigned SUM_W      = 12;

    localparam logic [COORD_W-1:0] COORD_SAT = '1;

    typedef enum logic [0:0] {
        StWaitVs,
        StCapture
    } cap_state_e;

    function automatic logic [7:0] pack_rgb332(input logic [7:0] r,
                                               input logic [7:0] g,
                                               input logic [7:0] b);
        return {r[7:5], g[7:5], b[7:6]};
    endfunction

endpackage

// File: rtl/vga_capture_8_timing_meter.sv
// vga_timing_meter: input register, sync polarity/edge detection, pixel coordinates,
// active geometry measurement and lock tracking for vga_capture_8.
module vga_timing_meter
    import vga_capture_8_pkg::*;
#(
    parameter bit C_HS_ACTIVE_LOW = 1'b1,
    parameter bit C_VS_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hs,
    input  logic               vs,
    input  logic               de,
    input  logic [7:0]         r,
    input  logic [7:0]         g,
    input  logic [7:0]         b,
    output logic [7:0]         pix_r,
    output logic [7:0]         pix_g,
    output logic [7:0]         pix_b,
    output logic               pix_valid,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_done,
    output logic [15:0]        meas_width,
    output logic [15:0]        meas_height,
    output logic               locked
);

    logic               hs_q, vs_q, de_q, vs_prev_q, de_prev_q;
    logic [7:0]         r_q, g_q, b_q;
    cap_state_e         state_q, state_d;
    logic [COORD_W-1:0] cnt_q, cnt_d;
    logic [COORD_W-1:0] y_q, y_d, y_line, x_pix;
    logic [COORD_W-1:0] width_q, width_d, height_q, height_d;
    logic [COORD_W-1:0] prev_w_q, prev_w_d, prev_h_q, prev_h_d;
    logic               locked_q, locked_d, frame_done_q, frame_done_d;
    logic               vs_start, de_rise, de_fall, de_overrun, frame_match;
    logic               unused_hs;

    // hs carries no line structure here; lines are delimited by de alone.
    assign unused_hs = hs_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            hs_q      <= hs ^ C_HS_ACTIVE_LOW;
            vs_q      <= vs ^ C_VS_ACTIVE_LOW;
            de_q      <= de;
            vs_prev_q <= vs_q;
            de_prev_q <= de_q;
            r_q       <= r;
            g_q       <= g;
            b_q       <= b;
        end
    end

    assign vs_start   = vs_q & ~vs_prev_q;
    assign de_rise    = de_q & ~de_prev_q;
    assign de_fall    = ~de_q & de_prev_q;
    assign x_pix      = de_rise ? '0 : cnt_q;
    assign de_overrun = de_q && (x_pix == COORD_SAT);
    assign y_line     = (de_fall && (y_q != COORD_SAT)) ? y_q + COORD_W'(1) : y_q;
    assign width_d    = de_fall ? cnt_q : width_q;

    // cnt holds the number of de-high cycles seen so far on the current line.
    always_comb begin
        cnt_d = cnt_q;
        if (de_q) begin
            cnt_d = (x_pix == COORD_SAT) ? x_pix : x_pix + COORD_W'(1);
        end
    end

    assign frame_match = (y_line == prev_h_q) && (width_d == prev_w_q) &&
                         (y_line != '0) && (width_d != '0);

    always_comb begin
        state_d      = state_q;
        y_d          = y_line;
        height_d     = height_q;
        prev_w_d     = prev_w_q;
        prev_h_d     = prev_h_q;
        locked_d     = locked_q;
        frame_done_d = 1'b0;
        case (state_q)
            StWaitVs: begin
                if (vs_start) begin
                    state_d      = StCapture;
                    frame_done_d = 1'b1;
                    y_d          = '0;
                end
            end
            StCapture: begin
                // A line ending on the same cycle is already folded into y_line.
                if (vs_start) begin
                    frame_done_d = 1'b1;
                    y_d          = '0;
                    height_d     = y_line;
                    prev_h_d     = y_line;
                    prev_w_d     = width_d;
                    locked_d     = frame_match;
                end
            end
            default: state_d = StWaitVs;
        endcase
        if (de_overrun) begin
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StWaitVs;
            cnt_q        <= '0;
            y_q          <= '0;
            width_q      <= '0;
            height_q     <= '0;
            prev_w_q     <= '0;
            prev_h_q     <= '0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            y_q          <= y_d;
            width_q      <= width_d;
            height_q     <= height_d;
            prev_w_q     <= prev_w_d;
            prev_h_q     <= prev_h_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_r       = r_q;
    assign pix_g       = g_q;
    assign pix_b       = b_q;
    assign pix_valid   = de_q && (state_q == StCapture);
    assign x           = x_pix;
    assign y           = y_q;
    assign frame_done  = frame_done_q;
    assign meas_width  = {{(16 - COORD_W){1'b0}}, width_q};
    assign meas_height = {{(16 - COORD_W){1'b0}}, height_q};
    assign locked      = locked_q;

endmodule

// File: rtl/vga_capture_8.sv
// vga_capture_8: decimates a parallel video stream 16x16 into RGB332 tile-buffer writes.
// Define VGA_CAPTURE_AVG_EN to write the mean of 16 horizontal pixels instead of a point sample.
module vga_capture_8
    import vga_capture_8_pkg::*;
#(
    parameter bit          C_HS_ACTIVE_LOW = 1'b1,
    parameter bit          C_VS_ACTIVE_LOW = 1'b1,
    parameter int unsigned C_MAX_COORD     = 1023,
    parameter int unsigned C_ADDR_LENGTH   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_vga_hs,
    input  logic        in_vga_vs,
    input  logic        in_vga_de,
    input  logic [7:0]  in_vga_r,
    input  logic [7:0]  in_vga_g,
    input  logic [7:0]  in_vga_b,
    output logic [31:0] data_length,
    output logic [31:0] data_address,
    output logic [7:0]  data_dout,
    output logic        data_we,
    output logic        frame_done,
    output logic [15:0] meas_width,
    output logic [15:0] meas_height,
    output logic        locked
);

    localparam logic [COORD_W-1:0] MAX_COORD = COORD_W'(C_MAX_COORD);

    logic [7:0]         pix_r, pix_g, pix_b;
    logic               pix_valid;
    logic [COORD_W-1:0] x, y;
    logic               in_tile_row, sample;
    logic [7:0]         px_colour;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [7:0]         dout_q;

    vga_timing_meter #(
        .C_HS_ACTIVE_LOW (C_HS_ACTIVE_LOW),
        .C_VS_ACTIVE_LOW (C_VS_ACTIVE_LOW)
    ) u_meter (
        .clk         (clk),
        .reset       (reset),
        .hs          (in_vga_hs),
        .vs          (in_vga_vs),
        .de          (in_vga_de),
        .r           (in_vga_r),
        .g           (in_vga_g),
        .b           (in_vga_b),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .pix_valid   (pix_valid),
        .x           (x),
        .y           (y),
        .frame_done  (frame_done),
        .meas_width  (meas_width),
        .meas_height (meas_height),
        .locked      (locked)
    );

    assign in_tile_row = pix_valid && (x <= MAX_COORD) && (y <= MAX_COORD) &&
                         (y[TILE_SHIFT-1:0] == '0);

`ifdef VGA_CAPTURE_AVG_EN
    logic [SUM_W-1:0] sum_r_q, sum_g_q, sum_b_q;
    logic [SUM_W-1:0] sum_r, sum_g, sum_b;
    logic             first_px;

    assign first_px = (x[TILE_SHIFT-1:0] == '0);

    // Running sums include the current pixel so the 16th pixel writes without an extra stage.
    assign sum_r = (first_px ? '0 : sum_r_q) + SUM_W'(pix_r);
    assign sum_g = (first_px ? '0 : sum_g_q) + SUM_W'(pix_g);
    assign sum_b = (first_px ? '0 : sum_b_q) + SUM_W'(pix_b);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
        end else if (pix_valid) begin
            sum_r_q <= sum_r;
            sum_g_q <= sum_g;
            sum_b_q <= sum_b;
        end
    end

    assign sample    = in_tile_row && (x[TILE_SHIFT-1:0] == '1);
    assign px_colour = pack_rgb332(sum_r[SUM_W-1:TILE_SHIFT], sum_g[SUM_W-1:TILE_SHIFT],
                                   sum_b[SUM_W-1:TILE_SHIFT]);
`else
    assign sample    = in_tile_row && (x[TILE_SHIFT-1:0] == '0);
    assign px_colour = pack_rgb332(pix_r, pix_g, pix_b);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            dout_q <= '0;
        end else begin
            we_q <= sample;
            if (sample) begin
                addr_q <= {y[9:4], x[9:4]};
                dout_q <= px_colour;
            end
        end
    end

    assign data_length  = 32'(C_ADDR_LENGTH);
    assign data_address = {{(32 - ADDR_W){1'b0}}, addr_q};
    assign data_dout    = dout_q;
    assign data_we      = we_q;

endmodule

// File: tb/tb_vga_capture_8.sv
// Scoreboard bench for vga_capture_8 on a reduced 80x56 raster (64x48 active).
module tb_vga_capture_8;

    localparam int HTOT   = 80;
    localparam int VTOT   = 56;
    localparam int VACT   = 48;
    localparam int HS_BEG = 68;
    localparam int HS_END = 76;
    localparam int VS_BEG = 50;
    localparam int VS_END = 52;
    localparam int NFR    = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_vga_hs, in_vga_vs, in_vga_de;
    logic [7:0]  in_vga_r, in_vga_g, in_vga_b;
    logic [31:0] data_length, data_address;
    logic [7:0]  data_dout;
    logic        data_we, frame_done, locked;
    logic [15:0] meas_width, meas_height;

    vga_capture_8 dut (
        .clk          (clk),
        .reset        (reset),
        .in_vga_hs    (in_vga_hs),
        .in_vga_vs    (in_vga_vs),
        .in_vga_de    (in_vga_de),
        .in_vga_r     (in_vga_r),
        .in_vga_g     (in_vga_g),
        .in_vga_b     (in_vga_b),
        .data_length  (data_length),
        .data_address (data_address),
        .data_dout    (data_dout),
        .data_we      (data_we),
        .frame_done   (frame_done),
        .meas_width   (meas_width),
        .meas_height  (meas_height),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int unsigned due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   writes = 0;
    int   wr_mark = 0;
    int   fd_count = 0;
    int   fd_expected = 0;
    bit   capturing = 1'b0;
    int unsigned sum_r, sum_g, sum_b;

    // Per-frame stimulus: active width, colour mode, reset line; then expected geometry.
    int fw[NFR] = '{64, 64, 64, 64, 32, 32, 32, 32, 40};
    int fm[NFR] = '{0, 0, 0, 1, 0, 0, 0, 0, 2};
    int fr[NFR] = '{-1, -1, -1, -1, -1, -1, 20, -1, -1};
    int eh[NFR] = '{0, 48, 48, 48, 48, 48, 0, 48, 48};
    int el[NFR] = '{0, 0, 1, 1, 0, 1, 0, 0, 0};
`ifdef VGA_CAPTURE_AVG_EN
    int en[NFR] = '{0, 12, 12, 12, 6, 6, 4, 6, 6};
`else
    int en[NFR] = '{0, 12, 12, 12, 6, 6, 4, 6, 9};
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [7:0] rgb332(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        return {r[7:5], g[7:5], b[7:6]};
    endfunction

    // Monitor: every strobe must match the oldest expected write, on its due cycle.
    always @(negedge clk) begin
        if (data_we === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) begin
                check("spurious_we", {31'b0, data_we}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("we_addr", data_address, {20'b0, mon_e.addr});
                check("we_data", {24'b0, data_dout}, {24'b0, mon_e.data});
                check("we_latency", cyc, mon_e.due);
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            mon_e = exp_q.pop_front();
            check("missing_we", {31'b0, data_we}, 32'd1);
        end
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic drive_frame(input int f);
        logic [7:0] cr, cg, cb;
        logic [11:0] a;
        bit de_v;
        for (int l = 0; l < VTOT; l++) begin
            for (int h = 0; h < HTOT; h++) begin
                @(posedge clk);
                #1;
                reset = !(l == fr[f] && h == 0);
                if (l == fr[f] && h == 1) begin
                    check("rst_we", {31'b0, data_we}, 32'd0);
                    check("rst_addr", data_address, 32'd0);
                    check("rst_dout", {24'b0, data_dout}, 32'd0);
                    check("rst_width", {16'b0, meas_width}, 32'd0);
                    check("rst_height", {16'b0, meas_height}, 32'd0);
                    check("rst_locked", {31'b0, locked}, 32'd0);
                    check("rst_length", data_length, 32'd4096);
                end
                if (l == fr[f] && h == 0) capturing = 1'b0;
                de_v = (l < VACT) && (h < fw[f]);
                in_vga_de = de_v;
                in_vga_hs = !(h >= HS_BEG && h < HS_END);
                in_vga_vs = !(l >= VS_BEG && l < VS_END);
                cr = 8'h00; cg = 8'h00; cb = 8'h00;
                if (fm[f] == 0) cr = 8'hFF;
                else if (fm[f] == 1 && h == 16 && l == 32) begin
                    cr = 8'h20; cg = 8'hE0; cb = 8'hC0;
                end else if (fm[f] == 2 && (h % 2) == 1) cr = 8'hFF;
                in_vga_r = cr; in_vga_g = cg; in_vga_b = cb;
                if (l == VS_BEG && h == 0) begin
                    capturing = 1'b1;
                    fd_expected++;
                end
                if (capturing && de_v && (l % 16) == 0) begin
                    a = 12'((l / 16) * 64 + (h / 16));
`ifdef VGA_CAPTURE_AVG_EN
                    if ((h % 16) == 0) begin
                        sum_r = 0; sum_g = 0; sum_b = 0;
                    end
                    sum_r += cr; sum_g += cg; sum_b += cb;
                    if ((h % 16) == 15)
                        exp_q.push_back('{a, rgb332(8'(sum_r / 16), 8'(sum_g / 16),
                                                    8'(sum_b / 16)), cyc + 2});
`else
                    if ((h % 16) == 0) exp_q.push_back('{a, rgb332(cr, cg, cb), cyc + 2});
`endif
                end
                if (l == VS_BEG + 1 && h == 4) begin
                    check("meas_width", {16'b0, meas_width}, 32'(fw[f]));
                    check("meas_height", {16'b0, meas_height}, 32'(eh[f]));
                    check("locked", {31'b0, locked}, 32'(el[f]));
                    check("writes_per_frame", 32'(writes - wr_mark), 32'(en[f]));
                    wr_mark = writes;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        in_vga_hs = 1'b1; in_vga_vs = 1'b1; in_vga_de = 1'b0;
        in_vga_r = 8'h00; in_vga_g = 8'h00; in_vga_b = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("init_we", {31'b0, data_we}, 32'd0);
        check("init_frame_done", {31'b0, frame_done}, 32'd0);
        check("init_locked", {31'b0, locked}, 32'd0);
        check("init_length", data_length, 32'd4096);
        reset = 1'b1;
        for (int f = 0; f < NFR; f++) drive_frame(f);
        repeat (10) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frame_done_count", 32'(fd_count), 32'(fd_expected));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
